// File: rtl/fetch_stage.sv
`timescale 1ns/1ps
// Instruction fetch stage: owns the PC, issues in-order imem requests under a credit limit,
// buffers responses and hands {pc, instr} to decode. Optional: FETCH_MISALIGN_CHECK_EN.

module fetch_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [W-1:0]               i_data,
  input  logic                       i_pop,
  output logic [W-1:0]               o_head,
  output logic [$clog2(DEPTH):0]     o_count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  r_mem [DEPTH];
  logic [PW-1:0] r_wr;
  logic [PW-1:0] r_rd;
  logic [CW-1:0] r_cnt;

  // Storage needs no reset: the head is only consumed while the count is non-zero.
  always_ff @(posedge clock) begin
    if (i_push && !i_flush) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else if (i_flush) begin
      r_wr  <= '0;
      r_rd  <= '0;
      r_cnt <= '0;
    end else begin
      if (i_push) r_wr <= r_wr + PW'(1);
      if (i_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(i_push) - CW'(i_pop);
    end
  end

  assign o_head  = r_mem[r_rd];
  assign o_count = r_cnt;
endmodule

module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0100_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic        out_misalign
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  logic [31:0]   r_fetch_pc;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;

  logic          w_halt;
  logic          w_mis_pend;
  logic [31:0]   w_mis_pc;
  logic [31:0]   w_redir_pc;
  logic          w_credit;
  logic          w_req_fire;
  logic          w_rsp;
  logic          w_rsp_take;
  logic          w_enq;
  logic          w_deq;
  ent_t          w_enq_ent;
  ent_t          w_head;
  logic [CW-1:0] w_q_cnt;
  logic [31:0]   w_pend_pc;
  logic [CW-1:0] w_unused_pend_cnt;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic        r_halt;
  logic        r_mis_pend;
  logic [31:0] r_mis_pc;

  // A misaligned target parks fetch and queues one marker entry the next cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_halt     <= 1'b0;
      r_mis_pend <= 1'b0;
      r_mis_pc   <= '0;
    end else if (redirect_valid) begin
      r_halt     <= |redirect_pc[1:0];
      r_mis_pend <= |redirect_pc[1:0];
      r_mis_pc   <= redirect_pc;
    end else begin
      r_mis_pend <= 1'b0;
    end
  end

  assign w_halt     = r_halt;
  assign w_mis_pend = r_mis_pend;
  assign w_mis_pc   = r_mis_pc;
  assign w_redir_pc = redirect_pc;
`else
  logic w_unused_lo;
  assign w_unused_lo = ^redirect_pc[1:0];
  assign w_halt      = 1'b0;
  assign w_mis_pend  = 1'b0;
  assign w_mis_pc    = '0;
  assign w_redir_pc  = {redirect_pc[31:2], 2'b00};
`endif

  assign w_credit       = ({1'b0, r_inflight} + {1'b0, w_q_cnt}) < (CW+1)'(DEPTH);
  assign imem_req_valid = !reset && !redirect_valid && !w_halt && w_credit;
  assign imem_req_addr  = r_fetch_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses with nothing outstanding (e.g. left over from before a reset) are ignored.
  assign w_rsp      = imem_rsp_valid && (r_inflight != '0);
  assign w_rsp_take = w_rsp && (r_drop == '0) && !redirect_valid;

  assign w_enq     = w_mis_pend || w_rsp_take;
  assign w_enq_ent = w_mis_pend ? ent_t'{pc: w_mis_pc, instr: 32'h0000_0013, mis: 1'b1}
                                : ent_t'{pc: w_pend_pc, instr: imem_rsp_data, mis: 1'b0};
  assign w_deq     = out_valid && out_ready;

  fetch_fifo #(.W(32), .DEPTH(DEPTH)) u_pend (
    .clock   (clock),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_req_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (w_rsp_take),
    .o_head  (w_pend_pc),
    .o_count (w_unused_pend_cnt)
  );

  fetch_fifo #(.W($bits(ent_t)), .DEPTH(DEPTH)) u_iq (
    .clock   (clock),
    .reset   (reset),
    .i_flush (redirect_valid),
    .i_push  (w_enq),
    .i_data  (w_enq_ent),
    .i_pop   (w_deq),
    .o_head  (w_head),
    .o_count (w_q_cnt)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_inflight <= '0;
      r_drop     <= '0;
    end else begin
      r_inflight <= r_inflight + CW'(w_req_fire) - CW'(w_rsp);
      if (redirect_valid) begin
        r_fetch_pc <= w_redir_pc;
        // Everything still outstanding after this cycle's response belongs to the old path.
        r_drop     <= r_inflight - CW'(w_rsp);
      end else begin
        if (w_req_fire)                r_fetch_pc <= r_fetch_pc + 32'd4;
        if (w_rsp && (r_drop != '0))   r_drop     <= r_drop - CW'(1);
      end
    end
  end

  assign out_valid    = (w_q_cnt != '0);
  assign out_pc       = out_valid ? w_head.pc    : '0;
  assign out_instr    = out_valid ? w_head.instr : '0;
  assign out_misalign = out_valid && w_head.mis;
endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
// Directed bench for fetch_stage: memory model with selectable latency, scoreboard on the
// decode side and an in-order address check on the request side.

module tb_fetch_stage;
  localparam logic [31:0] RESET_PC = 32'h0100_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;

  logic        clock = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        out_misalign;

  int checks = 0;
  int errors = 0;

  fetch_stage #(.RESET_PC(RESET_PC), .DEPTH(2)) dut (
    .clock          (clock),
    .reset          (reset),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_instr      (out_instr),
    .out_misalign   (out_misalign)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] mdat(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory: responses come back mem_lat cycles after acceptance, in order.
  logic [3:0]  m_v = '0;
  logic [31:0] m_a [4];
  int          mem_lat = 1;
  logic        inj_v = 1'b0;

  always @(posedge clock) begin
    m_v    <= {m_v[2:0], imem_req_valid && imem_req_ready};
    m_a[0] <= imem_req_addr;
    m_a[1] <= m_a[0];
    m_a[2] <= m_a[1];
    m_a[3] <= m_a[2];
  end

  assign imem_rsp_valid = m_v[mem_lat-1] | inj_v;
  assign imem_rsp_data  = inj_v ? 32'hDEAD_BEEF : mdat(m_a[mem_lat-1]);

  // Decode consumes exactly as many entries as the test has asked for.
  ent_t sb[$];
  int   want   = 0;
  int   n_seen = 0;
  int   n_done = 0;
  int   n_fire = 0;
  int   ncyc = 0;
  int   t_fire0 = -1;
  int   t_out0  = -1;
  logic [31:0] exp_req_pc = RESET_PC;
  logic halted = 1'b0;

  assign out_ready = (n_done < want);

  always @(posedge clock) n_done <= n_seen;

  always @(negedge clock) begin
    ent_t e;
    if (reset) begin
      exp_req_pc = RESET_PC;
      halted     = 1'b0;
      ncyc       = 0;
      t_fire0    = -1;
      t_out0     = -1;
    end else begin
      ncyc++;
      if (imem_req_valid && imem_req_ready) begin
        n_fire++;
        if (t_fire0 < 0) t_fire0 = ncyc;
        chk("req_addr", imem_req_addr, exp_req_pc);
        chk("req_while_halted", {31'b0, halted}, 32'd0);
        exp_req_pc = exp_req_pc + 32'd4;
      end
      if (redirect_valid) begin
        chk("req_in_redirect_cycle", {31'b0, imem_req_valid}, 32'd0);
        exp_req_pc = {redirect_pc[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
        halted = |redirect_pc[1:0];
`endif
      end
      if (out_valid && t_out0 < 0) t_out0 = ncyc;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: got pc %h instr %h expected none", out_pc, out_instr);
        end else begin
          e = sb.pop_front();
          chk("out_pc", out_pc, e.pc);
          chk("out_instr", out_instr, e.instr);
          chk("out_misalign", {31'b0, out_misalign}, {31'b0, e.mis});
        end
        n_seen++;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic expect_seq(input logic [31:0] pc0, input int n);
    for (int i = 0; i < n; i++) begin
      ent_t e;
      e.pc    = pc0 + 32'(4 * i);
      e.instr = mdat(e.pc);
      e.mis   = 1'b0;
      sb.push_back(e);
    end
    want += n;
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (n_done != want && k < budget) begin
      cyc(1);
      k++;
    end
    chk("drain_count", n_done, want);
  endtask

  task automatic redir(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    cyc(1);
    redirect_valid = 1'b0;
  endtask

  task automatic chk_reset_vals();
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_req_addr, RESET_PC);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_out_misalign", {31'b0, out_misalign}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1);
  end

  initial begin
    int saved_fire;
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    cyc(2);
    chk_reset_vals();

    // Stream from reset; first entry two cycles after the first request.
    expect_seq(RESET_PC, 4);
    reset = 1'b0;
    drain(60);
    chk("first_out_latency", 32'(t_out0 - t_fire0), 32'd2);

    // Decode stalls: only DEPTH fetches get ahead of decode, then drain in order.
    cyc(6);
    chk("stall_credit", 32'(n_fire - n_seen), 32'd2);
    chk("stall_out_valid", {31'b0, out_valid}, 32'd1);
    expect_seq(RESET_PC + 32'h10, 2);
    drain(40);

    // Two requests in flight at a redirect: both responses must be dropped.
    cyc(8);
    mem_lat = 3;
    redir(32'h0100_0040);
    chk("flush_out_valid_a", {31'b0, out_valid}, 32'd0);
    cyc(2);
    redir(32'h0100_0100);
    chk("flush_out_valid_b", {31'b0, out_valid}, 32'd0);
    expect_seq(32'h0100_0100, 2);
    drain(60);

    // Redirect coinciding with a response and with a decode handshake.
    cyc(12);
    mem_lat = 1;
    redir(32'h0100_0200);
    expect_seq(32'h0100_0200, 1);
    cyc(2);
    chk("coincide", {29'b0, out_valid, imem_rsp_valid, out_ready}, 32'd7);
    redir(32'h0100_0300);
    chk("flush_out_valid_c", {31'b0, out_valid}, 32'd0);
    expect_seq(32'h0100_0300, 2);
    drain(40);

    // PC wraps from the top of the address space.
    cyc(6);
    redir(32'hFFFF_FFF8);
    expect_seq(32'hFFFF_FFF8, 3);
    drain(40);

    cyc(6);
`ifdef FETCH_MISALIGN_CHECK_EN
    begin
      ent_t e;
      redir(32'h0100_0102);
      saved_fire = n_fire;
      e.pc    = 32'h0100_0102;
      e.instr = 32'h0000_0013;
      e.mis   = 1'b1;
      sb.push_back(e);
      want += 1;
      drain(20);
      cyc(8);
      chk("halt_no_requests", n_fire, saved_fire);
      redir(32'h0100_0200);
      expect_seq(32'h0100_0200, 2);
      drain(40);
    end
`else
    redir(32'h0100_0102);
    saved_fire = n_fire;
    expect_seq(32'h0100_0100, 2);
    drain(40);
    chk("aligned_redirect_fetches", {31'b0, n_fire > saved_fire}, 32'd1);
`endif

    // Reset mid-operation, then a spurious response before any real one returns.
    cyc(6);
    chk("pre_reset_out_valid", {31'b0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk_reset_vals();
    cyc(2);
    expect_seq(RESET_PC, 2);
    reset = 1'b0;
    inj_v = 1'b1;
    cyc(1);
    inj_v = 1'b0;
    drain(40);

    cyc(4);
    chk("scoreboard_empty", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
